// File: rtl/system_bus_mux_pkg.sv
// Shared types and constants for the single-master system bus: FSM states,
// load/store type encodings and the default RAM/IO address map.
package system_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    // Access size/sign types, carried through the bus untouched.
    localparam logic [2:0] TYPE_LB  = 3'b000;
    localparam logic [2:0] TYPE_LH  = 3'b001;
    localparam logic [2:0] TYPE_LW  = 3'b010;
    localparam logic [2:0] TYPE_LBU = 3'b100;
    localparam logic [2:0] TYPE_LHU = 3'b101;

    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] IO_BASE  = 32'h1000_0000;
    localparam logic [31:0] IO_MASK  = 32'hF000_0000;

endpackage

// File: rtl/system_bus_mux_addr_decoder.sv
// Combinational address decoder: per-slave base/mask match, then the lowest
// matching slave index is isolated into a one-hot select.
module bus_addr_decoder
    import system_bus_pkg::*;
#(
    parameter int                           N_SLAVES   = 2,
    parameter int                           ADDR_W     = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_BASE = {IO_BASE, RAM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_MASK = {IO_MASK, RAM_MASK}
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic                hit,
    output logic [N_SLAVES-1:0] sel
);

    logic [N_SLAVES-1:0] match;

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
        assign match[gi] = (addr & SLAVE_MASK[gi*ADDR_W +: ADDR_W])
                           == SLAVE_BASE[gi*ADDR_W +: ADDR_W];
    end

    // Two's-complement trick keeps only the lowest set bit.
    assign sel = match & (~match + N_SLAVES'(1));
    assign hit = |match;

endmodule

// File: rtl/system_bus_mux.sv
// Single-master, N-slave system bus with req/ready handshake and decode-miss errors.
// Optional ACCESS timeout enabled by defining SYSTEM_BUS_TIMEOUT_EN.
module system_bus_mux
    import system_bus_pkg::*;
#(
    parameter int                           N_SLAVES       = 2,
    parameter int                           ADDR_W         = 32,
    parameter int                           DATA_W         = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_BASE     = {IO_BASE, RAM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_MASK     = {IO_MASK, RAM_MASK},
    parameter int                           TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_req,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic                         m_we,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [2:0]                   m_type,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [N_SLAVES-1:0]          s_req,
    output logic [N_SLAVES-1:0]          s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [2:0]                   s_type,
    input  logic [N_SLAVES-1:0]          s_ready,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata
);

    logic [1:0]          state;
    logic [N_SLAVES-1:0] sel_q;
    logic                we_q;
    logic                dec_hit;
    logic [N_SLAVES-1:0] dec_sel;
    logic                sel_ready;
    logic [DATA_W-1:0]   rdata_sel;
    logic                timeout;

    bus_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Slave strobes come straight from state so an async reset drops them at once.
    assign s_req     = (state == ST_ACCESS) ? sel_q : '0;
    assign s_we      = s_req & {N_SLAVES{we_q}};
    assign m_ready   = (state == ST_RESP);
    assign sel_ready = |(s_ready & sel_q);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) rdata_sel |= s_rdata[i*DATA_W +: DATA_W];
        end
    end

`ifdef SYSTEM_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside ACCESS, so it reads 0 on the first ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  to_cnt <= '0;
        else if (state != ST_ACCESS) to_cnt <= '0;
        else                         to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_type  <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_req) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_type  <= m_type;
                        we_q    <= m_we;
                        sel_q   <= dec_sel;
                        if (dec_hit) begin
                            state <= ST_ACCESS;
                        end else begin
                            state   <= ST_RESP;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // A ready in the timeout cycle still wins.
                    if (sel_ready) begin
                        state   <= ST_RESP;
                        m_err   <= 1'b0;
                        m_rdata <= we_q ? '0 : rdata_sel;
                    end else if (timeout) begin
                        state   <= ST_RESP;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_system_bus_mux.sv
// Directed self-checking bench for system_bus_mux: default map instance plus an
// overlapping-map instance for the priority decode case.
module tb_system_bus_mux;
    import system_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [2:0]  m_type;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [1:0]  s_req;
    logic [1:0]  s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_type;
    logic [1:0]  s_ready;
    logic [63:0] s_rdata;

    logic        o_m_req;
    logic [31:0] o_m_addr;
    logic        o_m_ready;
    logic [31:0] o_m_rdata;
    logic        o_m_err;
    logic [1:0]  o_s_req;
    logic [1:0]  o_s_we;
    logic [31:0] o_s_addr;
    logic [31:0] o_s_wdata;
    logic [2:0]  o_s_type;
    logic [1:0]  o_s_ready;
    logic [63:0] o_s_rdata;

    int checks   = 0;
    int failures = 0;
    int stray;

    always #5 clk = ~clk;

    system_bus_mux #(
        .N_SLAVES (2), .ADDR_W (32), .DATA_W (32), .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .m_req (m_req), .m_addr (m_addr), .m_we (m_we), .m_wdata (m_wdata), .m_type (m_type),
        .m_ready (m_ready), .m_rdata (m_rdata), .m_err (m_err),
        .s_req (s_req), .s_we (s_we), .s_addr (s_addr), .s_wdata (s_wdata), .s_type (s_type),
        .s_ready (s_ready), .s_rdata (s_rdata)
    );

    system_bus_mux #(
        .N_SLAVES   (2), .ADDR_W (32), .DATA_W (32),
        .SLAVE_BASE ({32'h0000_0000, 32'h0000_0000}),
        .SLAVE_MASK ({32'h0000_0000, 32'hFFFF_0000})
    ) dut_ovl (
        .clk (clk), .rst_n (rst_n),
        .m_req (o_m_req), .m_addr (o_m_addr), .m_we (1'b0), .m_wdata (32'h0), .m_type (TYPE_LW),
        .m_ready (o_m_ready), .m_rdata (o_m_rdata), .m_err (o_m_err),
        .s_req (o_s_req), .s_we (o_s_we), .s_addr (o_s_addr), .s_wdata (o_s_wdata), .s_type (o_s_type),
        .s_ready (o_s_ready), .s_rdata (o_s_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; m_req = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_type = TYPE_LW;
        s_ready = '0; s_rdata = '0;
        o_m_req = 1'b0; o_m_addr = '0; o_s_ready = '0; o_s_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
        #1;
        check("rst_m_ready", m_ready, 0);
        check("rst_m_err",   m_err,   0);
        check("rst_s_req",   s_req,   0);
        check("rst_s_we",    s_we,    0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_s_addr",  s_addr,  0);
        check("rst_s_wdata", s_wdata, 0);
        check("rst_s_type",  s_type,  0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // 1: read RAM, slave ready in the first ACCESS cycle
        m_req = 1'b1; m_addr = 32'h0000_0040; m_we = 1'b0; m_type = TYPE_LBU;
        s_rdata = {32'h1111_2222, 32'hCAFE_F00D};
        tick;
        check("t1_s_req",   s_req,   2'b01);
        check("t1_s_we",    s_we,    2'b00);
        check("t1_no_rdy",  m_ready, 0);
        check("t1_s_type",  s_type,  TYPE_LBU);
        s_ready = 2'b01;
        tick;
        check("t1_m_ready", m_ready, 1);
        check("t1_m_rdata", m_rdata, 32'hCAFE_F00D);
        check("t1_m_err",   m_err,   0);
        check("t1_s_req_0", s_req,   0);
        m_req = 1'b0; s_ready = '0;
        tick;
        check("t1_pulse",   m_ready, 0);

        // 2: write IO with three stalls; wrong-slave ready and address change ignored
        m_req = 1'b1; m_addr = 32'h1000_0004; m_we = 1'b1; m_wdata = 32'h55; m_type = TYPE_LW;
        tick;
        m_addr = 32'h0000_0000; m_wdata = 32'hFFFF_FFFF;
        s_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            check("t2_s_we",    s_we,    2'b10);
            check("t2_stall",   m_ready, 0);
            tick;
        end
        check("t2_s_we_4",  s_we,    2'b10);
        check("t2_s_wdata", s_wdata, 32'h55);
        check("t2_s_addr",  s_addr,  32'h1000_0004);
        s_ready = 2'b10;
        tick;
        check("t2_m_ready", m_ready, 1);
        check("t2_m_err",   m_err,   0);
        check("t2_m_rdata", m_rdata, 0);
        m_req = 1'b0; s_ready = '0; m_we = 1'b0;
        tick;
        check("t2_pulse",   m_ready, 0);

        // 3: decode miss
        m_req = 1'b1; m_addr = 32'h2000_0000;
        tick;
        check("t3_s_req",   s_req,   0);
        check("t3_m_ready", m_ready, 1);
        check("t3_m_err",   m_err,   1);
        check("t3_m_rdata", m_rdata, 0);
        m_req = 1'b0;
        tick;
        check("t3_pulse",   m_ready, 0);

        // 4: overlapping map, lowest index wins; then an address only slave 1 matches
        o_m_req = 1'b1; o_m_addr = 32'h0000_0010;
        tick;
        check("t4_sel0",    o_s_req, 2'b01);
        o_s_ready = 2'b11;
        tick;
        check("t4_ready",   o_m_ready, 1);
        check("t4_rdata",   o_m_rdata, 32'hAAAA_0000);
        check("t4_no_s1",   o_s_req,   0);
        o_m_req = 1'b0; o_s_ready = '0;
        tick;
        o_m_req = 1'b1; o_m_addr = 32'h0001_0000;
        tick;
        check("t4_sel1",    o_s_req, 2'b10);
        o_s_ready = 2'b10; o_m_req = 1'b0;
        tick;
        check("t4_rdata1",  o_m_rdata, 32'hBBBB_0001);
        o_s_ready = '0;
        tick;

        // 5: slave never readies
        m_req = 1'b1; m_addr = 32'h0000_0100; m_we = 1'b0; s_rdata = {32'h0, 32'hDEAD_BEEF};
        tick;
        m_req = 1'b0;
`ifdef SYSTEM_BUS_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check("t5_s_req_hi", s_req,   2'b01);
            check("t5_wait",     m_ready, 0);
            tick;
        end
        check("t5_to_ready", m_ready, 1);
        check("t5_to_err",   m_err,   1);
        check("t5_to_rdata", m_rdata, 0);
        check("t5_to_s_req", s_req,   0);
        tick;
`else
        stray = 0;
        for (int i = 0; i < 1000; i++) begin
            stray += int'(m_ready);
            tick;
        end
        check("t5_no_ready", stray, 0);
        check("t5_in_acc",   s_req, 2'b01);
        rst_n = 1'b0;
        #1;
        check("t5_rst_sreq", s_req, 0);
        #2;
        rst_n = 1'b1;
        tick;
`endif

        // 6: reset during a stalled ACCESS, then a clean transaction
        m_req = 1'b1; m_addr = 32'h0000_0200;
        tick;
        m_req = 1'b0;
        tick;
        check("t6_pre_sreq", s_req, 2'b01);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sreq",  s_req,   0);
        check("t6_rst_ready", m_ready, 0);
        check("t6_rst_addr",  s_addr,  0);
        #2;
        rst_n = 1'b1;
        tick;
        m_req = 1'b1; m_addr = 32'h1000_0008; s_rdata = {32'h1234_5678, 32'h0};
        tick;
        check("t6_s_req",    s_req, 2'b10);
        s_ready = 2'b10; m_req = 1'b0;
        tick;
        check("t6_m_ready",  m_ready, 1);
        check("t6_m_rdata",  m_rdata, 32'h1234_5678);
        check("t6_m_err",    m_err,   0);
        s_ready = '0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
